// File: rtl/memory_access.sv
// memory_access: RISC-V memory stage; drives the data bus for loads/stores and builds the memory->writeback bundle.
// Optional MEM_MISALIGN_TRAP_EN flags misaligned accesses instead of aligning them down.
package memory_access_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        regwrite;
    logic [63:0] result;
    logic        misaligned;
  } memory_data_t;
endpackage

module memory_access
  import memory_access_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                in_valid,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                in_mem_read,
  input  logic                in_mem_write,
  input  logic [2:0]          in_funct3,
  input  logic [XLEN-1:0]     in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [4:0]          in_rd,
  input  logic                in_regwrite,
  output logic                dreq_valid,
  output logic [XLEN-1:0]     dreq_addr,
  output logic [2:0]          dreq_size,
  output logic [XLEN/8-1:0]   dreq_strobe,
  output logic [XLEN-1:0]     dreq_data,
  input  logic                dresp_data_ok,
  input  logic [XLEN-1:0]     dresp_data,
  output logic                stall_req,
  output memory_data_t        dataM
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  state_e state_q, state_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [1:0] size;
  logic [2:0] low_mask, off;
  logic [XLEN-1:0] addr, sh, ld, result;
  logic [XLEN/8-1:0] smask;
  logic misaligned, issue, sgn, st_en;

  assign size = in_funct3[1:0];
  assign low_mask = 3'((4'd1 << size) - 4'd1);
`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = in_valid && (in_mem_read || in_mem_write) && |(in_addr[2:0] & low_mask);
  assign addr = in_addr;
`else
  assign misaligned = 1'b0;
  assign addr = {in_addr[XLEN-1:3], in_addr[2:0] & ~low_mask};
`endif
  assign off = addr[2:0];
  assign issue = in_valid && (in_mem_read || in_mem_write) && !misaligned;

  always_comb begin
    state_d = state_q == IDLE ? (issue ? REQ : IDLE) :
              state_q == REQ  ? (dresp_data_ok ? DONE : REQ) :
              (stall ? DONE : IDLE);
    rdata_d = (state_q == REQ && dresp_data_ok) ? dresp_data : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // The request is live combinationally in the issuing IDLE cycle, then held through REQ.
  assign dreq_valid = !reset && (state_q == REQ || (state_q == IDLE && issue));
  assign stall_req  = dreq_valid;
  assign st_en      = dreq_valid && in_mem_write;
  assign dreq_addr  = addr;
  assign dreq_size  = {1'b0, size};
  assign smask = size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : size == 2'd2 ? 8'h0F : 8'hFF;
  assign dreq_strobe = st_en ? smask << off : '0;
  assign dreq_data   = st_en ? in_wdata << {off, 3'b000} : '0;

  assign sh  = rdata_q >> {off, 3'b000};
  assign sgn = !in_funct3[2];
  assign ld = size == 2'd0 ? {{(XLEN-8){sgn & sh[7]}}, sh[7:0]} :
              size == 2'd1 ? {{(XLEN-16){sgn & sh[15]}}, sh[15:0]} :
              size == 2'd2 ? {{(XLEN-32){sgn & sh[31]}}, sh[31:0]} : sh;
  assign result = misaligned ? in_addr : in_mem_write ? '0 : in_mem_read ? ld : in_addr;

  always_comb begin
    dataM = '0;
    if (!reset) begin
      dataM.valid      = in_valid;
      dataM.pc         = in_pc;
      dataM.rd         = in_rd;
      dataM.regwrite   = in_regwrite && !in_mem_write && !misaligned;
      dataM.result     = result;
      dataM.misaligned = misaligned;
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed scoreboard bench; expectations queued at issue, popped by a negedge monitor.
module tb_memory_access;
  import memory_access_pkg::*;
  logic clk = 1'b0;
  logic reset, stall, in_valid, in_mem_read, in_mem_write, in_regwrite, dresp_data_ok;
  logic [2:0] in_funct3;
  logic [63:0] in_pc, in_addr, in_wdata, dresp_data;
  logic [4:0] in_rd;
  logic dreq_valid, stall_req;
  logic [63:0] dreq_addr, dreq_data;
  logic [2:0] dreq_size;
  logic [7:0] dreq_strobe;
  memory_data_t dataM;

  memory_access #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid), .in_pc(in_pc),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .stall_req(stall_req), .dataM(dataM)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } bus_t;
  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        regwrite;
    logic [63:0] result;
    logic        mis;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  bus_t be;
  res_t re;
  int errors = 0, checks = 0, episodes = 0, stall_cycles = 0;
  logic prev_dv = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (stall_req) stall_cycles++;
      if (dreq_valid && !prev_dv) begin
        episodes++;
        if (bus_q.size() == 0) check("unexpected request", 64'd1, 64'd0);
        else begin
          be = bus_q.pop_front();
          check("dreq_addr", dreq_addr, be.addr);
          check("dreq_size", 64'(dreq_size), 64'(be.size));
          check("dreq_strobe", 64'(dreq_strobe), 64'(be.strobe));
          if (be.strobe != 8'h00) check("dreq_data", dreq_data, be.data);
        end
      end
      if (dataM.valid && !stall && !stall_req) begin
        if (res_q.size() == 0) check("unexpected commit", 64'd1, 64'd0);
        else begin
          re = res_q.pop_front();
          check("pc", dataM.pc, re.pc);
          check("rd", 64'(dataM.rd), 64'(re.rd));
          check("regwrite", 64'(dataM.regwrite), 64'(re.regwrite));
          check("result", dataM.result, re.result);
          check("misaligned", 64'(dataM.misaligned), 64'(re.mis));
        end
      end
    end
    prev_dv = dreq_valid;
  end

  task automatic run_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                        input int lat, input int hold, input logic bus,
                        input logic [63:0] e_addr, input logic [2:0] e_size, input logic [7:0] e_strobe,
                        input logic [63:0] e_data, input logic [63:0] e_res, input logic e_rw,
                        input logic e_mis);
    @(posedge clk); #1;
    episodes = 0;
    stall_cycles = 0;
    in_pc = in_pc + 64'd4;
    in_rd = in_rd + 5'd1;
    in_valid = 1'b1; in_mem_read = rd_en; in_mem_write = wr_en; in_funct3 = f3;
    in_addr = addr; in_wdata = wdata; in_regwrite = !wr_en;
    if (bus) bus_q.push_back('{e_addr, e_size, e_strobe, e_data});
    res_q.push_back('{in_pc, in_rd, e_rw, e_res, e_mis});
    if (bus) begin
      repeat (lat) @(posedge clk);
      #1 dresp_data_ok = 1'b1; dresp_data = rdata; stall = (hold > 0);
      @(posedge clk);
      #1 dresp_data_ok = 1'b0; dresp_data = '1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold stall_req", 64'(stall_req), 64'd0);
        check("hold dreq_valid", 64'(dreq_valid), 64'd0);
        check("hold result", dataM.result, e_res);
        @(posedge clk); #1;
      end
      stall = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    check("request episodes", 64'(episodes), bus ? 64'd1 : 64'd0);
    check("stall_req cycles", 64'(stall_cycles), bus ? 64'(lat + 1) : 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; stall = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'b011;
    in_addr = 64'h100; in_wdata = '0; in_pc = 64'h8000_0000; in_rd = 5'd0; in_regwrite = 1'b1;
    repeat (2) @(negedge clk);
    check("reset dreq_valid", 64'(dreq_valid), 64'd0);
    check("reset stall_req", 64'(stall_req), 64'd0);
    check("reset dreq_strobe", 64'(dreq_strobe), 64'd0);
    check("reset dataM zero", 64'(|dataM), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_mem_read = 1'b0; reset = 1'b0;

    // LB sign-extended, response two cycles after the first request
    run_op(1, 0, 3'b000, 64'h1003, 0, 64'h0000_0000_8000_0000, 2, 0, 1,
           64'h1003, 3'd0, 8'h00, 0, 64'hFFFF_FFFF_FFFF_FF80, 1, 0);
    run_op(0, 1, 3'b001, 64'h2006, 64'hABCD, 0, 1, 0, 1,
           64'h2006, 3'd1, 8'hC0, 64'hABCD_0000_0000_0000, 0, 0, 0);
    // LWU held in DONE by stall for four cycles
    run_op(1, 0, 3'b110, 64'h4004, 0, 64'h8765_4321_0000_0000, 1, 4, 1,
           64'h4004, 3'd2, 8'h00, 0, 64'h0000_0000_8765_4321, 1, 0);
    run_op(0, 0, 3'b000, 64'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h55, 1, 0);
    run_op(1, 0, 3'b010, 64'h4004, 0, 64'h8765_4321_0000_0000, 3, 0, 1,
           64'h4004, 3'd2, 8'h00, 0, 64'hFFFF_FFFF_8765_4321, 1, 0);
    run_op(1, 0, 3'b001, 64'h4002, 0, 64'h0000_0000_F00D_0000, 1, 0, 1,
           64'h4002, 3'd1, 8'h00, 0, 64'hFFFF_FFFF_FFFF_F00D, 1, 0);
    run_op(0, 1, 3'b011, 64'h3000, 64'h1122_3344_5566_7788, 0, 2, 1, 1,
           64'h3000, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 0, 0, 0);
    run_op(0, 1, 3'b000, 64'h6005, 64'h1234, 0, 1, 0, 1,
           64'h6005, 3'd0, 8'h20, 64'h0012_3400_0000_0000, 0, 0, 0);
    run_op(1, 0, 3'b100, 64'h5007, 0, 64'hDEAD_BEEF_CAFE_BABE, 1, 0, 1,
           64'h5007, 3'd0, 8'h00, 0, 64'h0000_0000_0000_00DE, 1, 0);
    run_op(1, 0, 3'b011, 64'h5000, 0, 64'hDEAD_BEEF_CAFE_BABE, 2, 1, 1,
           64'h5000, 3'd3, 8'h00, 0, 64'hDEAD_BEEF_CAFE_BABE, 1, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    run_op(1, 0, 3'b010, 64'h1002, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h1002, 0, 1);
`else
    run_op(1, 0, 3'b010, 64'h1002, 0, 64'h0000_0000_1234_5678, 1, 0, 1,
           64'h1000, 3'd2, 8'h00, 0, 64'h0000_0000_1234_5678, 1, 0);
`endif

    // Reset asserted while the request is outstanding; late response must be ignored
    @(posedge clk); #1;
    episodes = 0;
    bus_q.push_back('{64'h7000, 3'd3, 8'h00, 64'h0});
    in_valid = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'b011; in_addr = 64'h7000;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort dreq_valid", 64'(dreq_valid), 64'd0);
    check("abort stall_req", 64'(stall_req), 64'd0);
    check("abort dataM zero", 64'(|dataM), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; in_mem_read = 1'b0;
    dresp_data_ok = 1'b1; dresp_data = 64'h1111_2222_3333_4444;
    @(negedge clk);
    check("late ok stall_req", 64'(stall_req), 64'd0);
    check("late ok dreq_valid", 64'(dreq_valid), 64'd0);
    @(posedge clk); #1 dresp_data_ok = 1'b0;
    repeat (2) @(negedge clk);
    check("late ok stays idle", 64'(stall_req | dreq_valid), 64'd0);
    check("abort episodes", 64'(episodes), 64'd1);

    run_op(0, 0, 3'b000, 64'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h77, 1, 0);
    repeat (2) @(posedge clk);
    check("bus queue drained", 64'(bus_q.size()), 64'd0);
    check("result queue drained", 64'(res_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
